// File: rtl/screen_alert_sequencer.sv
// Fades a wrong-password alert image over the base screen, holds it, then fades back out.
// Optional HOLD blinking is compiled in with SCREEN_ALERT_BLINK_EN.
module screen_alert_sequencer #(
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 60,
  parameter int BLINK_FRAMES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_begin,
  input  logic        trigger,
  input  logic [12:0] pix_ind,
  input  logic [15:0] base_color,
  input  logic [15:0] alert_color,
  output logic [15:0] oled_color,
  output logic        active,
  output logic        done
);

  // state    | meaning
  // IDLE     | level 0, oled_color follows base_color
  // FADE_IN  | level steps up every FRAMES_PER_STEP frames
  // HOLD     | full alert for HOLD_FRAMES frames
  // FADE_OUT | level steps down; retrigger returns to FADE_IN
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FADE_IN  = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_FADE_OUT = 2'd3;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] oled_color_q, oled_color_d;
  logic        done_q, done_d;
  logic [3:0]  eff_level;

  // Pixel index only addresses the upstream ROMs.
  logic unused_pix;
  assign unused_pix = ^pix_ind;

  function automatic logic [15:0] blend(input logic [15:0] b, input logic [15:0] a,
                                        input logic [3:0] l);
    logic [9:0] r, g, bl;
    logic [3:0] il;
    il = 4'd8 - l;
    r  = 10'(a[15:11]) * 10'(l) + 10'(b[15:11]) * 10'(il);
    g  = 10'(a[10:5])  * 10'(l) + 10'(b[10:5])  * 10'(il);
    bl = 10'(a[4:0])   * 10'(l) + 10'(b[4:0])   * 10'(il);
    return {r[7:3], g[8:3], bl[7:3]};
  endfunction

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        level_d = 4'd0;
        if (trigger) begin
          state_d    = S_FADE_IN;
          step_cnt_d = 8'd0;
        end
      end
      S_FADE_IN: begin
        // Reachable at level 8 only via a retrigger before the first fade-out step.
        if (level_q == 4'd8) begin
          state_d    = S_HOLD;
          hold_cnt_d = 8'd0;
        end else if (frame_begin) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = 8'd0;
            level_d    = level_q + 4'd1;
            if (level_q == 4'd7) begin
              state_d    = S_HOLD;
              hold_cnt_d = 8'd0;
            end
          end else begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end
      end
      S_HOLD: begin
        level_d = 4'd8;
        if (trigger) begin
          hold_cnt_d = 8'd0;
        end else if (frame_begin) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = S_FADE_OUT;
            step_cnt_d = 8'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
      end
      S_FADE_OUT: begin
        if (trigger) begin
          state_d    = S_FADE_IN;
          step_cnt_d = 8'd0;
        end else if (frame_begin) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = 8'd0;
            level_d    = level_q - 4'd1;
            if (level_q == 4'd1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = 4'd0;
      end
    endcase
  end

`ifdef SCREEN_ALERT_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if ((state_d == S_HOLD && state_q != S_HOLD) || (state_q == S_HOLD && trigger)) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b0;
    end else if (state_q == S_HOLD && frame_begin) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign eff_level = (state_q == S_HOLD && phase_q) ? 4'd0 : level_q;
`else
  localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  assign eff_level = level_q;
`endif

  assign oled_color_d = blend(base_color, alert_color, eff_level);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      level_q      <= 4'd0;
      step_cnt_q   <= 8'd0;
      hold_cnt_q   <= 8'd0;
      oled_color_q <= 16'h0000;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      step_cnt_q   <= step_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      oled_color_q <= oled_color_d;
      done_q       <= done_d;
    end
  end

  assign oled_color = oled_color_q;
  assign active     = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
